// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp encodings, R-type funct values
// and the decoder result bundle.
package alu_pkg;

   // ALU control codes driven into the execute-stage ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   // ALUOp as produced by the main decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_AND   = 2'b11
   } aluop_e;

   // R-type funct field values
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;

   // Decoder result: control code plus unknown-funct flag
   typedef struct packed {
      logic [3:0] ctl;
      logic       illegal;
   } alu_dec_t;

endpackage

// File: rtl/alu_ctl_dec.sv
// Pure combinational ALUOp/funct -> ALU control decoder.
module alu_ctl_dec
   import alu_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   output alu_dec_t   o_dec
);

   // Map ALUOp (and funct for R-type) onto the ALU control encoding
   always_comb begin
      o_dec.ctl     = ALU_AND;
      o_dec.illegal = 1'b0;
      case (aluop_e'(i_alu_op))
         ALUOP_ADD: o_dec.ctl = ALU_ADD;
         ALUOP_SUB: o_dec.ctl = ALU_SUB;
         ALUOP_AND: o_dec.ctl = ALU_AND;
         ALUOP_RTYPE: begin
            case (i_funct)
               F_ADD, F_ADDU: o_dec.ctl = ALU_ADD;
               F_SUB, F_SUBU: o_dec.ctl = ALU_SUB;
               F_AND:         o_dec.ctl = ALU_AND;
               F_OR:          o_dec.ctl = ALU_OR;
               F_XOR:         o_dec.ctl = ALU_XOR;
               F_NOR:         o_dec.ctl = ALU_NOR;
               F_SLT:         o_dec.ctl = ALU_SLT;
               default: begin
                  // unknown funct: AND code, flagged so the write is suppressed
                  o_dec.ctl     = ALU_AND;
                  o_dec.illegal = 1'b1;
               end
            endcase
         end
         default: o_dec.ctl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control, holds the ID/EX register under
// stall/flush, and forwards operands from EX/MEM and MEM/WB into the ALU.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              exmem_reg_write,
   input  logic [REG_AW-1:0] exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_reg_write,
   input  logic [REG_AW-1:0] memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              ex_valid,
   output logic [3:0]        alu_ctl,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_illegal
);

   alu_dec_t          w_dec;
   logic              w_bubble;
   logic [DATA_W-1:0] w_fwd_a;
   logic [DATA_W-1:0] w_fwd_b;

   logic              r_valid;
   logic [3:0]        r_ctl;
   logic              r_alu_src;
   logic              r_reg_write;
   logic              r_illegal;
   logic [REG_AW-1:0] r_rs;
   logic [REG_AW-1:0] r_rt;
   logic [REG_AW-1:0] r_rd;
   logic [DATA_W-1:0] r_rs_data;
   logic [DATA_W-1:0] r_rt_data;
   logic [DATA_W-1:0] r_imm;

   alu_ctl_dec u_dec (
      .i_alu_op (id_alu_op),
      .i_funct  (id_funct),
      .o_dec    (w_dec)
   );

   // flush beats stall; an empty decode slot also becomes a bubble when not stalled
   assign w_bubble = flush | (~stall & ~id_valid);

   // ID/EX register: clear on reset/bubble, hold on stall, else capture decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_ctl       <= ALU_AND;
         r_alu_src   <= 1'b0;
         r_reg_write <= 1'b0;
         r_illegal   <= 1'b0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm       <= '0;
      end else if (w_bubble) begin
         r_valid     <= 1'b0;
         r_ctl       <= ALU_AND;
         r_alu_src   <= 1'b0;
         r_reg_write <= 1'b0;
         r_illegal   <= 1'b0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_rd        <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm       <= '0;
      end else if (!stall) begin
         r_valid     <= 1'b1;
         r_ctl       <= w_dec.ctl;
         r_alu_src   <= id_alu_src;
         r_reg_write <= id_reg_write & ~w_dec.illegal;
         r_illegal   <= w_dec.illegal;
         r_rs        <= id_rs;
         r_rt        <= id_rt;
         r_rd        <= id_rd;
         r_rs_data   <= id_rs_data;
         r_rt_data   <= id_rt_data;
         r_imm       <= id_imm;
      end
   end

   // rs forwarding: EX/MEM first, then MEM/WB, never for register 0
   always_comb begin
      w_fwd_a = r_rs_data;
      if (r_rs != '0) begin
         if (exmem_reg_write && (exmem_rd == r_rs))
            w_fwd_a = exmem_result;
         else if (memwb_reg_write && (memwb_rd == r_rs))
            w_fwd_a = memwb_result;
      end
   end

   // rt forwarding: same priority as rs; bypassed below when the immediate is selected
   always_comb begin
      w_fwd_b = r_rt_data;
      if (r_rt != '0) begin
         if (exmem_reg_write && (exmem_rd == r_rt))
            w_fwd_b = exmem_result;
         else if (memwb_reg_write && (memwb_rd == r_rt))
            w_fwd_b = memwb_result;
      end
   end

   assign alu_a        = w_fwd_a;
   assign alu_b        = r_alu_src ? r_imm : w_fwd_b;
   assign ex_valid     = r_valid;
   assign alu_ctl      = r_ctl;
   assign ex_rd        = r_rd;
   assign ex_reg_write = r_reg_write;
   assign ex_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a random
// run checked against a behavioural model of the ID/EX stage.
module tb_alu_issue_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset, stall, flush, id_valid;
   logic [1:0]    id_alu_op;
   logic [5:0]    id_funct;
   logic          id_alu_src, id_reg_write;
   logic [AW-1:0] id_rs, id_rt, id_rd;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic          exmem_reg_write, memwb_reg_write;
   logic [AW-1:0] exmem_rd, memwb_rd;
   logic [DW-1:0] exmem_result, memwb_result;
   logic          ex_valid, ex_reg_write, ex_illegal;
   logic [3:0]    alu_ctl;
   logic [DW-1:0] alu_a, alu_b;
   logic [AW-1:0] ex_rd;

   int n_chk = 0;
   int n_err = 0;

   // model of the instruction currently held in the stage
   logic          m_valid, m_src, m_rw, m_ill;
   logic [3:0]    m_ctl;
   logic [AW-1:0] m_rs, m_rt, m_rd;
   logic [DW-1:0] m_rsd, m_rtd, m_imm;

   int unsigned rtab [int];   // legal R-type funct -> control code
   int unsigned legal_f [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
   int unsigned legal_c [9] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'hD, 4'hC, 4'h7};

   alu_issue_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] fwd(input logic [AW-1:0] src, input logic [DW-1:0] rf);
      if (src == 0) return rf;
      if (exmem_reg_write && exmem_rd == src) return exmem_result;
      if (memwb_reg_write && memwb_rd == src) return memwb_result;
      return rf;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_src = 0; m_rw = 0; m_ill = 0; m_ctl = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
   endtask

   // advance the model with the inputs present before the edge, then clock
   task automatic tick();
      logic [3:0] c;
      logic       ill;
      if (flush || (!stall && !id_valid)) model_clear();
      else if (!stall) begin
         ill = 0;
         case (id_alu_op)
            2'd0: c = 4'h2;
            2'd1: c = 4'h6;
            2'd3: c = 4'h0;
            default: begin
               if (rtab.exists(int'(id_funct))) c = 4'(rtab[int'(id_funct)]);
               else begin c = 4'h0; ill = 1; end
            end
         endcase
         m_valid = 1; m_ctl = c; m_ill = ill; m_rw = id_reg_write && !ill;
         m_src = id_alu_src; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
         m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, DW'(ex_valid), DW'(m_valid));
      chk({tag, ".ctl"},   DW'(alu_ctl), DW'(m_ctl));
      chk({tag, ".a"},     alu_a, fwd(m_rs, m_rsd));
      chk({tag, ".b"},     alu_b, m_src ? m_imm : fwd(m_rt, m_rtd));
      chk({tag, ".rd"},    DW'(ex_rd), DW'(m_rd));
      chk({tag, ".rw"},    DW'(ex_reg_write), DW'(m_rw));
      chk({tag, ".ill"},   DW'(ex_illegal), DW'(m_ill));
   endtask

   task automatic set_id(input logic [1:0] op, input logic [5:0] f, input logic src,
                         input logic rw, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic [DW-1:0] rsd,
                         input logic [DW-1:0] rtd, input logic [DW-1:0] imm);
      id_valid = 1; id_alu_op = op; id_funct = f; id_alu_src = src; id_reg_write = rw;
      id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
   endtask

   task automatic fwd_off();
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   initial begin
      for (int i = 0; i < 9; i++) rtab[int'(legal_f[i])] = legal_c[i];
      reset = 1; stall = 0; flush = 0;
      set_id(2'd0, 6'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_valid = 0;
      fwd_off();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      reset = 0;

      // load live data, then hit reset mid-cycle
      set_id(2'd2, 6'h25, 0, 1, 5'd4, 5'd6, 5'd9, 32'h1234, 32'h5678, 0);
      tick();
      chk("pre_reset.valid", DW'(ex_valid), 1);
      #2 reset = 1;
      #1;
      model_clear();
      chk("async_rst.valid", DW'(ex_valid), 0);
      chk("async_rst.ctl", DW'(alu_ctl), 0);
      chk("async_rst.a", alu_a, 0);
      chk("async_rst.b", alu_b, 0);
      chk("async_rst.rw", DW'(ex_reg_write), 0);
      chk("async_rst.ill", DW'(ex_illegal), 0);
      #1 reset = 0;
      set_id(2'd0, 6'd0, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0);
      tick();
      chk("add.ctl", DW'(alu_ctl), 32'h2);
      chk("add.a", alu_a, 32'd5);
      chk("add.b", alu_b, 32'd7);

      // decode sweep
      for (int i = 0; i < 9; i++) begin
         set_id(2'd2, 6'(legal_f[i]), 0, 1, 5'd1, 5'd2, 5'd3, 1, 2, 0);
         tick();
         chk($sformatf("dec_f%0h.ctl", legal_f[i]), DW'(alu_ctl), DW'(legal_c[i]));
         chk($sformatf("dec_f%0h.ill", legal_f[i]), DW'(ex_illegal), 0);
      end
      set_id(2'd1, 6'h3F, 0, 1, 1, 2, 3, 1, 2, 0); tick();
      chk("dec_sub.ctl", DW'(alu_ctl), 32'h6);
      set_id(2'd3, 6'h20, 0, 1, 1, 2, 3, 1, 2, 0); tick();
      chk("dec_and.ctl", DW'(alu_ctl), 32'h0);
      set_id(2'd2, 6'h00, 0, 1, 1, 2, 3, 1, 2, 0); tick();
      chk("illegal.ctl", DW'(alu_ctl), 0);
      chk("illegal.ill", DW'(ex_illegal), 1);
      chk("illegal.rw", DW'(ex_reg_write), 0);
      chk("illegal.valid", DW'(ex_valid), 1);

      // double forward: EX/MEM beats MEM/WB
      set_id(2'd0, 0, 0, 1, 5'd3, 5'd5, 5'd7, 32'h1111, 32'h2222, 0); tick();
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBBBB;
      #1 chk("dfwd.exmem", alu_a, 32'hAAAA);
      exmem_reg_write = 0;
      #1 chk("dfwd.memwb", alu_a, 32'hBBBB);
      fwd_off();
      #1 chk("dfwd.none", alu_a, 32'h1111);

      // register 0 is never forwarded
      set_id(2'd0, 0, 0, 1, 5'd0, 5'd5, 5'd7, 32'h0, 32'h2222, 0); tick();
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
      #1 chk("r0.a", alu_a, 32'h0);
      fwd_off();

      // immediate select ignores rt forwarding
      set_id(2'd0, 0, 1, 1, 5'd1, 5'd4, 5'd7, 32'h10, 32'h20, 32'hFFFF_FFFC); tick();
      exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h99;
      #1 chk("imm.b", alu_b, 32'hFFFF_FFFC);
      fwd_off();

      // stall holds for 3 cycles while id_* changes
      set_id(2'd0, 0, 0, 1, 5'd1, 5'd2, 5'd5, 32'h11, 32'h22, 0); tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         set_id(2'd1, 6'($urandom), 1, 0, 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom);
         tick();
         chk($sformatf("stall%0d.ctl", i), DW'(alu_ctl), 32'h2);
         chk($sformatf("stall%0d.a", i), alu_a, 32'h11);
         chk($sformatf("stall%0d.b", i), alu_b, 32'h22);
         chk($sformatf("stall%0d.rd", i), DW'(ex_rd), 5);
         chk($sformatf("stall%0d.valid", i), DW'(ex_valid), 1);
      end
      // forwarding still tracks during the hold
      memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'hCAFE;
      #1 chk("stall.fwd_b", alu_b, 32'hCAFE);
      fwd_off();
      flush = 1; tick();
      chk("flush.valid", DW'(ex_valid), 0);
      chk("flush.rw", DW'(ex_reg_write), 0);
      chk("flush.ctl", DW'(alu_ctl), 0);
      stall = 0; flush = 0;

      // random traffic against the model
      for (int n = 0; n < 400; n++) begin
         stall    = ($urandom_range(0, 4) == 0);
         flush    = ($urandom_range(0, 9) == 0);
         id_valid = ($urandom_range(0, 6) != 0);
         id_alu_op    = 2'($urandom);
         id_funct     = ($urandom_range(0, 3) != 0) ? 6'(legal_f[$urandom_range(0, 8)]) : 6'($urandom);
         id_alu_src   = 1'($urandom);
         id_reg_write = 1'($urandom);
         id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
         id_rd = 5'($urandom);
         id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
         tick();
         exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
         memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
         #1 check_all($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
